mem_bus_arbiter: RTL and testbench

//  Shares one word-wide single-port memory between the multicycle RV32 core and the

---
 rtl/mem_bus_pkg.sv | 30 +++
 rtl/mem_lane_fmt.sv | 53 +++++
 rtl/mem_bus_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared constants and types for the memory bus arbiter.
//   F3_*      RV32 load/store funct3 encodings
//   state_e   four-phase access sequence
//   req_e     requester identity (CPU or UART loader)
package mem_bus_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        ACK     = 2'd3
    } state_e;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_LDR = 1'b1
    } req_e;

    // Encodings with no RV32 load/store meaning.
    function automatic logic f3_illegal(input logic [2:0] f3);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// mem_lane_fmt: combinational RV32 sub-word formatter.
//   i_funct3  access size / signedness
//   i_addr    byte offset within the word
//   i_wdata   right-aligned store data
//   i_rdata   raw memory word
//   o_be      byte write enables
//   o_wdata   store data replicated across lanes
//   o_rdata   selected and sign/zero-extended load data
//   o_fault   illegal funct3 or misaligned access
module mem_lane_fmt
    import mem_bus_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_fault
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_sext;

    always_comb begin
        w_byte  = i_rdata[{i_addr, 3'b000} +: 8];
        w_half  = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
        w_sext  = ~i_funct3[2];
        o_fault = f3_illegal(i_funct3)
                || ((i_funct3[1:0] == 2'b01) && i_addr[0])
                || ((i_funct3[1:0] == 2'b10) && (i_addr != 2'b00));
        case (i_funct3[1:0])
            2'b00: begin
                o_be    = 4'b0001 << i_addr;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{24{w_sext & w_byte[7]}}, w_byte};
            end
            2'b01: begin
                o_be    = i_addr[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = {{16{w_sext & w_half[15]}}, w_half};
            end
            default: begin
                o_be    = 4'hF;
                o_wdata = i_wdata;
                o_rdata = i_rdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-port BRAM between the RV32 core and the
// UART loader. Each access runs IDLE -> ISSUE -> CAPTURE -> ACK.
//   i_clk, i_rst_n                 clock, async active-low reset
//   i_cpu_* / o_cpu_*              core port (funct3 sub-word accesses)
//   i_ldr_* / o_ldr_*              loader port (full words only)
//   o_mem_*, i_mem_rdata           BRAM port, 1-cycle read latency
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter bit FAIR   = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [31:0]       i_cpu_addr,
    input  logic [31:0]       i_cpu_wdata,
    input  logic [2:0]        i_cpu_funct3,
    output logic              o_cpu_ack,
    output logic [31:0]       o_cpu_rdata,
    output logic              o_cpu_misalign,
    input  logic              i_ldr_req,
    input  logic              i_ldr_we,
    input  logic [31:0]       i_ldr_addr,
    input  logic [31:0]       i_ldr_wdata,
    output logic              o_ldr_ack,
    output logic [31:0]       o_ldr_rdata,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [3:0]        o_mem_be,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    input  logic [31:0]       i_mem_rdata
);

    state_e            r_state;
    req_e              r_last;
    req_e              r_gnt;
    logic              r_we;
    logic [ADDR_W+1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [2:0]        r_f3;
    logic [31:0]       r_cpu_rdata;
    logic [31:0]       r_ldr_rdata;

    logic        w_pick_cpu;
    logic        w_issue;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_rdata;
    logic        w_fault;
    logic        w_unused;

    // High address bits wrap silently; loader byte offset is ignored.
    assign w_unused = ^{i_cpu_addr[31:ADDR_W+2], i_ldr_addr[31:ADDR_W+2], i_ldr_addr[1:0]};

    // Loader accesses are latched as aligned SW/LW so the shared formatter
    // passes them through untouched and can never fault them.
    mem_lane_fmt u_fmt (
        .i_funct3 (r_f3),
        .i_addr   (r_addr[1:0]),
        .i_wdata  (r_wdata),
        .i_rdata  (i_mem_rdata),
        .o_be     (w_be),
        .o_wdata  (w_wdata),
        .o_rdata  (w_rdata),
        .o_fault  (w_fault)
    );

    // Under contention FAIR hands the bus to whoever did not have it last.
    assign w_pick_cpu = i_cpu_req && (!i_ldr_req || !FAIR || (r_last == REQ_LDR));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_last      <= REQ_LDR;
            r_gnt       <= REQ_CPU;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_f3        <= F3_W;
            r_cpu_rdata <= '0;
            r_ldr_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_cpu_req || i_ldr_req) begin
                        r_state <= ISSUE;
                        if (w_pick_cpu) begin
                            r_gnt   <= REQ_CPU;
                            r_last  <= REQ_CPU;
                            r_we    <= i_cpu_we;
                            r_addr  <= i_cpu_addr[ADDR_W+1:0];
                            r_wdata <= i_cpu_wdata;
                            r_f3    <= i_cpu_funct3;
                        end else begin
                            r_gnt   <= REQ_LDR;
                            r_last  <= REQ_LDR;
                            r_we    <= i_ldr_we;
                            r_addr  <= {i_ldr_addr[ADDR_W+1:2], 2'b00};
                            r_wdata <= i_ldr_wdata;
                            r_f3    <= F3_W;
                        end
                    end
                end
                ISSUE:   r_state <= CAPTURE;
                CAPTURE: begin
                    r_state <= ACK;
                    if (r_gnt == REQ_CPU) r_cpu_rdata <= w_fault ? 32'd0 : w_rdata;
                    else                  r_ldr_rdata <= w_rdata;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // A faulted access keeps its four-cycle slot but never touches memory.
    assign w_issue     = (r_state == ISSUE) && !w_fault;
    assign o_mem_en    = w_issue;
    assign o_mem_we    = w_issue && r_we;
    assign o_mem_be    = (w_issue && r_we) ? w_be : 4'h0;
    assign o_mem_addr  = w_issue ? r_addr[ADDR_W+1:2] : '0;
    assign o_mem_wdata = (w_issue && r_we) ? w_wdata : 32'd0;

    assign o_cpu_ack      = (r_state == ACK) && (r_gnt == REQ_CPU);
    assign o_cpu_rdata    = o_cpu_ack ? r_cpu_rdata : 32'd0;
    assign o_cpu_misalign = o_cpu_ack && w_fault;
    assign o_ldr_ack      = (r_state == ACK) && (r_gnt == REQ_LDR);
    assign o_ldr_rdata    = o_ldr_ack ? r_ldr_rdata : 32'd0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;
    import mem_bus_pkg::*;

    localparam int AW = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        cpu_req = 0, cpu_we = 0, ldr_req = 0, ldr_we = 0;
    logic [31:0] cpu_addr = 0, cpu_wdata = 0, ldr_addr = 0, ldr_wdata = 0;
    logic [2:0]  cpu_f3 = 0;
    logic        cpu_ack, cpu_mis, ldr_ack, mem_en, mem_we;
    logic [31:0] cpu_rdata, ldr_rdata, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic [AW-1:0] mem_addr;

    logic        c2_req = 0, l2_req = 0;
    logic        d2_cack, d2_cmis, d2_lack, d2_en, d2_we;
    logic [31:0] d2_crd, d2_lrd, d2_wd;
    logic [31:0] d2_mrd = 32'd0;
    logic [3:0]  d2_be;
    logic [AW-1:0] d2_addr;

    mem_bus_arbiter #(.ADDR_W(AW), .FAIR(1'b1)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr),
        .i_cpu_wdata(cpu_wdata), .i_cpu_funct3(cpu_f3),
        .o_cpu_ack(cpu_ack), .o_cpu_rdata(cpu_rdata), .o_cpu_misalign(cpu_mis),
        .i_ldr_req(ldr_req), .i_ldr_we(ldr_we), .i_ldr_addr(ldr_addr),
        .i_ldr_wdata(ldr_wdata), .o_ldr_ack(ldr_ack), .o_ldr_rdata(ldr_rdata),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_be(mem_be),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
    );

    mem_bus_arbiter #(.ADDR_W(AW), .FAIR(1'b0)) dut_fixed (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cpu_req(c2_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr),
        .i_cpu_wdata(cpu_wdata), .i_cpu_funct3(cpu_f3),
        .o_cpu_ack(d2_cack), .o_cpu_rdata(d2_crd), .o_cpu_misalign(d2_cmis),
        .i_ldr_req(l2_req), .i_ldr_we(ldr_we), .i_ldr_addr(ldr_addr),
        .i_ldr_wdata(ldr_wdata), .o_ldr_ack(d2_lack), .o_ldr_rdata(d2_lrd),
        .o_mem_en(d2_en), .o_mem_we(d2_we), .o_mem_be(d2_be),
        .o_mem_addr(d2_addr), .o_mem_wdata(d2_wd), .i_mem_rdata(d2_mrd)
    );

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // BRAM with one-cycle read latency
    logic [31:0] bram [0:4095];
    initial begin
        for (int i = 0; i < 4096; i++) bram[i] = 32'd0;
        mem_rdata = 32'd0;
    end
    always @(posedge clk) begin
        if (mem_en) begin
            for (int i = 0; i < 4; i++)
                if (mem_we && mem_be[i]) bram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
            mem_rdata <= bram[mem_addr];
        end
    end

    // ---------------- transaction-level reference model ----------------
    typedef struct { logic we; logic [3:0] be; logic [AW-1:0] addr; logic [31:0] wd; } iss_t;
    typedef struct { logic cpu; logic [31:0] rd; logic mis; logic chk; } ack_t;

    iss_t exp_iss [int];
    ack_t exp_ack [int];
    logic [31:0] mmem [0:4095];
    initial for (int i = 0; i < 4096; i++) mmem[i] = 32'd0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        m_last_ldr = 1'b1;
    int          m_free = 0;
    logic        m_pick, m_flt;
    int          m_off, m_sz;
    logic [AW-1:0] m_idx;
    logic [31:0] m_w, m_v, m_mask;
    iss_t        m_is;
    ack_t        m_ak;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_last_ldr = 1'b1;
            m_free = 0;
            exp_iss.delete();
            exp_ack.delete();
        end else if (cyc >= m_free && (cpu_req || ldr_req)) begin
            m_pick = cpu_req && (!ldr_req || m_last_ldr);
            m_last_ldr = !m_pick;
            m_free = cyc + 4;
            m_is.we = 0; m_is.be = 0; m_is.addr = 0; m_is.wd = 0;
            if (m_pick) begin
                m_off = int'(cpu_addr[1:0]);
                m_sz  = (cpu_f3[1:0] == 2'b00) ? 1 : (cpu_f3[1:0] == 2'b01) ? 2 : 4;
                m_flt = (cpu_f3 inside {3'd3, 3'd6, 3'd7}) || (m_off % m_sz != 0);
                m_idx = cpu_addr[AW+1:2];
                m_v = 32'd0;
                if (!m_flt) begin
                    m_is.we = cpu_we;
                    m_is.addr = m_idx;
                    if (cpu_we) begin
                        for (int i = 0; i < 4; i++) begin
                            m_is.wd[8*i +: 8] = cpu_wdata[8*(i % m_sz) +: 8];
                            if (i >= m_off && i < m_off + m_sz) begin
                                m_is.be[i] = 1'b1;
                                mmem[m_idx][8*i +: 8] = cpu_wdata[8*(i - m_off) +: 8];
                            end
                        end
                    end else begin
                        m_w = mmem[m_idx];
                        m_mask = (m_sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*m_sz)) - 32'd1);
                        m_v = (m_w >> (8*m_off)) & m_mask;
                        if (!cpu_f3[2] && m_sz < 4 && m_v[8*m_sz-1]) m_v = m_v | ~m_mask;
                    end
                    exp_iss[cyc+1] = m_is;
                end
                m_ak.cpu = 1'b1; m_ak.rd = m_v; m_ak.mis = m_flt; m_ak.chk = !cpu_we || m_flt;
            end else begin
                m_idx = ldr_addr[AW+1:2];
                m_is.we = ldr_we; m_is.addr = m_idx; m_is.be = 4'hF; m_is.wd = ldr_wdata;
                if (ldr_we) mmem[m_idx] = ldr_wdata;
                exp_iss[cyc+1] = m_is;
                m_ak.cpu = 1'b0; m_ak.rd = mmem[m_idx]; m_ak.mis = 1'b0; m_ak.chk = !ldr_we;
            end
            exp_ack[cyc+3] = m_ak;
        end
    end

    // Every-cycle comparison against the model
    iss_t c_is;
    ack_t c_ak;
    logic c_cpu, c_ldr;
    always @(negedge clk) begin
        if (exp_iss.exists(cyc)) begin
            c_is = exp_iss[cyc];
            chk("mem_en", {31'd0, mem_en}, 32'd1);
            chk("mem_addr", {20'd0, mem_addr}, {20'd0, c_is.addr});
            chk("mem_we", {31'd0, mem_we}, {31'd0, c_is.we});
            if (c_is.we) begin
                chk("mem_be", {28'd0, mem_be}, {28'd0, c_is.be});
                chk("mem_wdata", mem_wdata, c_is.wd);
            end
        end else begin
            chk("mem_en_idle", {31'd0, mem_en}, 32'd0);
        end
        c_cpu = 0; c_ldr = 0;
        if (exp_ack.exists(cyc)) begin
            c_ak = exp_ack[cyc];
            c_cpu = c_ak.cpu;
            c_ldr = !c_ak.cpu;
        end
        chk("cpu_ack", {31'd0, cpu_ack}, {31'd0, c_cpu});
        chk("ldr_ack", {31'd0, ldr_ack}, {31'd0, c_ldr});
        if (c_cpu) begin
            chk("cpu_misalign", {31'd0, cpu_mis}, {31'd0, c_ak.mis});
            if (c_ak.chk) chk("cpu_rdata", cpu_rdata, c_ak.rd);
        end
        if (c_ldr && c_ak.chk) chk("ldr_rdata", ldr_rdata, c_ak.rd);
    end

    // ---------------- directed stimulus ----------------
    logic        s_en;
    logic [3:0]  s_be;
    logic [AW-1:0] s_addr;
    logic [31:0] s_wd;

    task automatic cpu_op(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [2:0] f3, output logic [31:0] rd, output logic mis,
                          output int lat);
        @(negedge clk);
        cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_f3 = f3; cpu_req = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin s_en = mem_en; s_be = mem_be; s_addr = mem_addr; s_wd = mem_wdata; end
        end while (!cpu_ack && lat < 16);
        if (!cpu_ack) chk("cpu_ack_timeout", 32'd0, 32'd1);
        rd = cpu_rdata; mis = cpu_mis;
        cpu_req = 1'b0;
    endtask

    task automatic ldr_op(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output int lat);
        @(negedge clk);
        ldr_we = we; ldr_addr = a; ldr_wdata = wd; ldr_req = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin s_en = mem_en; s_be = mem_be; s_addr = mem_addr; s_wd = mem_wdata; end
        end while (!ldr_ack && lat < 16);
        if (!ldr_ack) chk("ldr_ack_timeout", 32'd0, 32'd1);
        rd = ldr_rdata;
        ldr_req = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    logic [31:0] rd;
    logic        mis;
    int          lat;
    int          ca[$], la[$];

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
        chk("rst_ldr_ack", {31'd0, ldr_ack}, 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        rst_n = 1'b1;

        // SB to byte 1 of word 1
        cpu_op(1'b1, 32'h5, 32'hA7, F3_B, rd, mis, lat);
        chk("sb_lat", lat, 3);
        chk("sb_en", {31'd0, s_en}, 32'd1);
        chk("sb_addr", {20'd0, s_addr}, 32'd1);
        chk("sb_be", {28'd0, s_be}, 32'b0010);
        chk("sb_wdata", s_wd, 32'hA7A7A7A7);

        // Sub-word loads from a loader-written word
        ldr_op(1'b1, 32'h4, 32'h80FF7F01, rd, lat);
        cpu_op(1'b0, 32'h6, 0, F3_B, rd, mis, lat);  chk("lb", rd, 32'hFFFFFFFF);
        cpu_op(1'b0, 32'h7, 0, F3_BU, rd, mis, lat); chk("lbu", rd, 32'h00000080);
        cpu_op(1'b0, 32'h6, 0, F3_H, rd, mis, lat);  chk("lh", rd, 32'hFFFF80FF);
        cpu_op(1'b0, 32'h4, 0, F3_HU, rd, mis, lat); chk("lhu", rd, 32'h00007F01);

        // Faults: misaligned LW, illegal funct3
        cpu_op(1'b0, 32'h2, 0, F3_W, rd, mis, lat);
        chk("lw_mis_flag", {31'd0, mis}, 32'd1);
        chk("lw_mis_rdata", rd, 32'd0);
        chk("lw_mis_en", {31'd0, s_en}, 32'd0);
        chk("lw_mis_lat", lat, 3);
        cpu_op(1'b0, 32'h0, 0, 3'b011, rd, mis, lat);
        chk("f3_bad_flag", {31'd0, mis}, 32'd1);
        chk("f3_bad_en", {31'd0, s_en}, 32'd0);
        cpu_op(1'b1, 32'h1, 32'h1234, F3_H, rd, mis, lat);
        chk("sh_odd_flag", {31'd0, mis}, 32'd1);

        // Loader full-word write ignores addr[1:0]
        ldr_op(1'b1, 32'h11, 32'h12345678, rd, lat);
        chk("ldr_be", {28'd0, s_be}, 32'hF);
        chk("ldr_addr", {20'd0, s_addr}, 32'd4);
        chk("ldr_lat", lat, 3);
        cpu_op(1'b0, 32'h10, 0, F3_W, rd, mis, lat);
        chk("lw_after_ldr", rd, 32'h12345678);

        // SH upper half through a wrapped address
        cpu_op(1'b1, 32'h4012, 32'hBEEF, F3_H, rd, mis, lat);
        chk("sh_be", {28'd0, s_be}, 32'b1100);
        chk("sh_wdata", s_wd, 32'hBEEFBEEF);
        chk("sh_addr", {20'd0, s_addr}, 32'd4);
        ldr_op(1'b0, 32'h10, 0, rd, lat);
        chk("ldr_read", rd, 32'hBEEF5678);

        // Round-robin contention (last grant was the loader)
        @(negedge clk);
        cpu_we = 0; cpu_addr = 32'h10; cpu_f3 = F3_W; ldr_we = 0; ldr_addr = 32'h10;
        cpu_req = 1; ldr_req = 1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (cpu_ack) ca.push_back(k);
            if (ldr_ack) la.push_back(k);
            if (k == 11) begin cpu_req = 0; ldr_req = 0; end
        end
        chk("rr_cpu_n", ca.size(), 2);
        chk("rr_ldr_n", la.size(), 1);
        if (ca.size() == 2 && la.size() == 1) begin
            chk("rr_cpu0", ca[0], 3);
            chk("rr_ldr0", la[0], 7);
            chk("rr_cpu1", ca[1], 11);
        end

        // Fixed priority instance: loader starved while the CPU holds req
        ca.delete(); la.delete();
        @(negedge clk);
        c2_req = 1; l2_req = 1;
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            if (d2_cack) ca.push_back(k);
            if (d2_lack) begin la.push_back(k); l2_req = 0; end
            if (k == 13) c2_req = 0;
        end
        c2_req = 0; l2_req = 0;
        chk("fix_cpu_n", ca.size(), 4);
        chk("fix_ldr_n", la.size(), 1);
        if (la.size() == 1) chk("fix_ldr_at", la[0], 19);

        // Reset during ISSUE of a loader write
        @(negedge clk);
        ldr_we = 1; ldr_addr = 32'h800; ldr_wdata = 32'hDEADBEEF; ldr_req = 1;
        @(posedge clk);
        #2;
        chk("pre_rst_en", {31'd0, mem_en}, 32'd1);
        chk("pre_rst_we", {31'd0, mem_we}, 32'd1);
        rst_n = 0;
        #1;
        chk("rst_mid_en", {31'd0, mem_en}, 32'd0);
        chk("rst_mid_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mid_ldr_ack", {31'd0, ldr_ack}, 32'd0);
        chk("rst_mid_cpu_ack", {31'd0, cpu_ack}, 32'd0);
        ldr_req = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        cpu_op(1'b0, 32'h10, 0, F3_W, rd, mis, lat);
        chk("post_rst_lat", lat, 3);
        chk("post_rst_rd", rd, 32'hBEEF5678);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
